// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helper for the parametrised sync FIFO.
package sync_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bundle for sync_fifo_param; master drives, slave is the FIFO.
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  import sync_fifo_pkg::*;

  localparam int CW = ptr_w(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              wr_overflow;
  logic              rd_underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  rd_data, fifo_full, fifo_empty,
    input  almost_full, almost_empty, count,
    input  wr_overflow, rd_underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output rd_data, fifo_full, fifo_empty,
    output almost_full, almost_empty, count,
    output wr_overflow, rd_underflow
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// Dual-port storage array; read port is registered, or combinational
// when SYNC_FIFO_FWFT_EN is defined (first-word-fall-through).
module sync_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // head word is always on the output; pop only moves the pointer
  logic unused_fwft;
  assign unused_fwft = &{1'b0, rst_n, re_i};
  assign rdata_o = mem_q[raddr_i];
`else
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with count, almost flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input logic               clk,
  input logic               rst_n,
  sync_fifo_param_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          ovf_q, udf_q;
  logic          wr_ok, rd_ok;

  // a read frees a slot in the same edge, so full+read still takes the write
  assign rd_ok = bus.rd_en && !empty_q;
  assign wr_ok = bus.wr_en && (!full_q || rd_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_ok);
    rd_ptr_d = rd_ptr_q + PW'(rd_ok);
    count_d  = count_q;
    unique case (1'b1)
      (wr_ok && !rd_ok): count_d = count_q + PW'(1);
      (rd_ok && !wr_ok): count_d = count_q - PW'(1);
      default: ;
    endcase
    full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
               (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    empty_d  = (wr_ptr_d == rd_ptr_d);
    afull_d  = (count_d >= PW'(AF_LEVEL));
    aempty_d = (count_d <= PW'(AE_LEVEL));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= bus.wr_en && !wr_ok;
      udf_q    <= bus.rd_en && !rd_ok;
    end
  end

  sync_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (bus.wr_data),
    .re_i    (rd_ok),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (bus.rd_data)
  );

  assign bus.count        = count_q;
  assign bus.fifo_full    = full_q;
  assign bus.fifo_empty   = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.wr_overflow  = ovf_q;
  assign bus.rd_underflow = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param at DEPTH=4, DATA_W=8, AF=3, AE=1.
module tb_sync_fifo_param;

  localparam int DW = 8;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DP)) bus ();

  sync_fifo_param #(
    .DATA_W   (DW),
    .DEPTH    (DP),
    .AF_LEVEL (3),
    .AE_LEVEL (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, got, exp);
  endtask

  // inputs change on negedge, sampled at posedge, observed next negedge
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    @(negedge clk);
  endtask

  task automatic st(input string tag, input int c, input int f,
                    input int e, input int af, input int ae);
    chk({tag, ".count"}, int'(bus.count), c);
    chk({tag, ".full"}, int'(bus.fifo_full), f);
    chk({tag, ".empty"}, int'(bus.fifo_empty), e);
    chk({tag, ".afull"}, int'(bus.almost_full), af);
    chk({tag, ".aempty"}, int'(bus.almost_empty), ae);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;
    @(negedge clk);
    st("rst", 0, 0, 1, 0, 1);
    chk("rst.rd_data", int'(bus.rd_data), 0);
    chk("rst.ovf", int'(bus.wr_overflow), 0);
    chk("rst.udf", int'(bus.rd_underflow), 0);
    rst_n = 1'b1;

`ifdef SYNC_FIFO_FWFT_EN
    cyc(1, 8'd7, 0);
    chk("fw.rd7", int'(bus.rd_data), 7);
    st("fw.w7", 1, 0, 0, 0, 1);
    cyc(0, 8'd0, 1);
    st("fw.pop", 0, 0, 1, 0, 1);
    cyc(1, 8'd8, 0);
    cyc(1, 8'd9, 0);
    chk("fw.head8", int'(bus.rd_data), 8);
    cyc(0, 8'd0, 1);
    chk("fw.head9", int'(bus.rd_data), 9);
    st("fw.pop1", 1, 0, 0, 0, 1);
    cyc(0, 8'd0, 1);
    cyc(0, 8'd0, 1);
    chk("fw.udf", int'(bus.rd_underflow), 1);
    st("fw.end", 0, 0, 1, 0, 1);
`else
    // fill then overflow
    cyc(1, 8'd5, 0);
    st("w5", 1, 0, 0, 0, 1);
    cyc(1, 8'd10, 0);
    st("w10", 2, 0, 0, 0, 0);
    cyc(1, 8'd20, 0);
    st("w20", 3, 0, 0, 1, 0);
    cyc(1, 8'd30, 0);
    st("w30", 4, 1, 0, 1, 0);
    cyc(1, 8'd40, 0);
    chk("ovf.pulse", int'(bus.wr_overflow), 1);
    chk("ovf.count", int'(bus.count), 4);
    cyc(0, 8'd0, 0);
    chk("ovf.clear", int'(bus.wr_overflow), 0);

    // drain then underflow
    cyc(0, 8'd0, 1);
    chk("r5", int'(bus.rd_data), 5);
    st("r5", 3, 0, 0, 1, 0);
    cyc(0, 8'd0, 1);
    chk("r10", int'(bus.rd_data), 10);
    cyc(0, 8'd0, 1);
    chk("r20", int'(bus.rd_data), 20);
    st("r20", 1, 0, 0, 0, 1);
    cyc(0, 8'd0, 1);
    chk("r30", int'(bus.rd_data), 30);
    st("r30", 0, 0, 1, 0, 1);
    cyc(0, 8'd0, 1);
    chk("udf.pulse", int'(bus.rd_underflow), 1);
    chk("udf.hold", int'(bus.rd_data), 30);
    cyc(0, 8'd0, 0);
    chk("udf.clear", int'(bus.rd_underflow), 0);

    // wrap-around
    cyc(1, 8'd35, 0);
    cyc(1, 8'd40, 0);
    cyc(1, 8'd50, 0);
    cyc(0, 8'd0, 1);
    chk("wr.r35", int'(bus.rd_data), 35);
    cyc(0, 8'd0, 1);
    chk("wr.r40", int'(bus.rd_data), 40);
    cyc(1, 8'd60, 0);
    cyc(1, 8'd70, 0);
    cyc(1, 8'd80, 0);
    st("wr.full", 4, 1, 0, 1, 0);
    cyc(0, 8'd0, 1);
    chk("wr.r50", int'(bus.rd_data), 50);
    cyc(0, 8'd0, 1);
    chk("wr.r60", int'(bus.rd_data), 60);
    cyc(0, 8'd0, 1);
    chk("wr.r70", int'(bus.rd_data), 70);
    cyc(0, 8'd0, 1);
    chk("wr.r80", int'(bus.rd_data), 80);
    st("wr.empty", 0, 0, 1, 0, 1);

    // simultaneous access when full, then when empty
    cyc(1, 8'd1, 0);
    cyc(1, 8'd2, 0);
    cyc(1, 8'd3, 0);
    cyc(1, 8'd4, 0);
    cyc(1, 8'd5, 1);
    chk("sf.rd", int'(bus.rd_data), 1);
    chk("sf.ovf", int'(bus.wr_overflow), 0);
    st("sf", 4, 1, 0, 1, 0);
    cyc(0, 8'd0, 1);
    chk("sf.r2", int'(bus.rd_data), 2);
    cyc(0, 8'd0, 1);
    cyc(0, 8'd0, 1);
    cyc(0, 8'd0, 1);
    chk("sf.r5", int'(bus.rd_data), 5);
    st("sf.empty", 0, 0, 1, 0, 1);
    cyc(1, 8'd6, 1);
    chk("se.udf", int'(bus.rd_underflow), 1);
    chk("se.hold", int'(bus.rd_data), 5);
    st("se", 1, 0, 0, 0, 1);
    cyc(0, 8'd0, 1);
    chk("se.r6", int'(bus.rd_data), 6);

    // asynchronous reset mid-operation
    cyc(1, 8'd11, 0);
    cyc(1, 8'd12, 0);
    cyc(1, 8'd13, 0);
    cyc(0, 8'd0, 1);
    chk("pre.rd", int'(bus.rd_data), 11);
    cyc(1, 8'd14, 0);
    st("pre", 3, 0, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    st("arst", 0, 0, 1, 0, 1);
    chk("arst.rd_data", int'(bus.rd_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 8'd99, 0);
    st("post.w", 1, 0, 0, 0, 1);
    cyc(0, 8'd0, 1);
    chk("post.r99", int'(bus.rd_data), 99);
    st("post.r", 0, 0, 1, 0, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
